counter_1: RTL and testbench



---
 rtl/counter_1.sv | 46 ++++
 tb/tb_counter_1.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/counter_1.sv
// Enabled up-counter with a fixed step that wraps to zero at a programmable terminal count.
// Used as the tick/position counter building block in the display and game datapath.
module counter_1 #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int MAX_VALUE = (1 << WIDTH) - 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  output logic [WIDTH-1:0] C
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH + 1)'(MAX_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   sum_ext;

  // The extra bit keeps C + STEP exact so the overflow compare never aliases.
  always_comb begin
    count_ext = {1'b0, count_q};
    sum_ext   = count_ext + STEP_W;
    count_d   = count_q;
    if (En) begin
      if (count_ext >= MAX_W || sum_ext > MAX_W) begin
        count_d = '0;
      end else begin
        count_d = sum_ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign C = count_q;

endmodule

// File: tb/tb_counter_1.sv
// Directed bench for counter_1: a default-parameter instance plus two small-terminal instances
// that exercise both wrap conditions (sum overshoots terminal, count already at terminal).
module tb_counter_1;

  logic       clk;
  logic       rst;
  logic       en;
  logic       en_b;
  logic [7:0] c;
  logic [3:0] c_b;
  logic [3:0] c_c;

  int tests_run    = 0;
  int tests_failed = 0;

  counter_1 dut (
    .Clk (clk),
    .Rst (rst),
    .En  (en),
    .C   (c)
  );

  // Terminal 10 with step 3: 9 + 3 overshoots, so wrap comes from the sum compare.
  counter_1 #(.WIDTH(4), .STEP(3), .MAX_VALUE(10)) dut_b (
    .Clk (clk),
    .Rst (rst),
    .En  (en_b),
    .C   (c_b)
  );

  // Terminal 9 with step 3: the count lands exactly on the terminal before wrapping.
  counter_1 #(.WIDTH(4), .STEP(3), .MAX_VALUE(9)) dut_c (
    .Clk (clk),
    .Rst (rst),
    .En  (en_b),
    .C   (c_c)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic applyStimulus(input logic rst_val, input logic en_val, input logic en_b_val);
    rst  = rst_val;
    en   = en_val;
    en_b = en_b_val;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int exp_b [6];
    int exp_c [5];
    exp_b = '{0, 3, 6, 9, 0, 3};
    exp_c = '{0, 3, 6, 9, 0};

    applyStimulus(1'b1, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1 checkOutput("reset_async_initial", 32'(c), 0);

    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("reset_hold_%0d", i), 32'(c), 0);
    end

    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("count_%0d", i), 32'(c), 32'(i));
    end

    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("hold_%0d", i), 32'(c), 5);
    end

    en = 1'b1;
    repeat (5) tick();
    checkOutput("resume_to_10", 32'(c), 10);

    // Mid-count reset pulse lands between edges; C must clear without a clock.
    en = 1'b0;
    @(posedge clk);
    #1 checkOutput("pre_reset_value", 32'(c), 10);
    #1 rst = 1'b0;
    #3 checkOutput("mid_reset_async", 32'(c), 0);
    #7 rst = 1'b1;
    en = 1'b1;
    tick();
    checkOutput("post_reset_first", 32'(c), 1);
    repeat (4) tick();
    checkOutput("post_reset_fifth", 32'(c), 5);

    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("wrap_reset", 32'(c), 0);
    rst = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      checkOutput($sformatf("wrap_step_%0d", i), 32'(c), 32'(i));
    end

    en = 1'b0;
    tick();
    checkOutput("wrap_hold_at_max", 32'(c), 255);
    en = 1'b1;
    tick();
    checkOutput("wrap_to_zero", 32'(c), 0);
    tick();
    checkOutput("wrap_restart", 32'(c), 1);

    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("param_reset_b", 32'(c_b), 0);
    checkOutput("param_reset_c", 32'(c_c), 0);
    rst = 1'b1;
    checkOutput("param_b_0", 32'(c_b), 32'(exp_b[0]));
    for (int i = 1; i < 6; i++) begin
      tick();
      checkOutput($sformatf("param_b_%0d", i), 32'(c_b), 32'(exp_b[i]));
      if (i < 5) begin
        checkOutput($sformatf("param_c_%0d", i), 32'(c_c), 32'(exp_c[i]));
      end
    end
    checkOutput("param_default_idle", 32'(c), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
